multi_tick_timer: RTL and testbench

Parametrised bank of independent programmable tick timers for the game's timing fabric (scroll speed, enemy spawn, fuel drain, countdowns). Each channel latches a period and a mode at start and emits a single-cycle `tick` every `period` enabled clocks (periodic) or once (one-shot). Adds start/stop control, a global pause, and sticky completion flags, replacing single-channel fixed-threshold counters.

---
 rtl/timer_pkg.sv | 11 +
 rtl/timer_channel.sv | 80 ++++++++
 rtl/multi_tick_timer.sv | 41 ++++
 tb/tb_multi_tick_timer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and defaults for the multi-channel tick timer.
package timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_t;

    localparam int TIMER_WIDTH_DEFAULT = 26;

endpackage

// File: rtl/timer_channel.sv
// One programmable tick timer: latched period/mode, elapsed counter, sticky done.
// state | meaning:  IDLE | stopped, waiting for start;  RUN | counting enabled cycles toward P-1
module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH_DEFAULT
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [WIDTH-1:0] period_i,
    input  logic             oneshot_i,
    input  logic             clr_done_i,
    output logic             tick_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    timer_state_t     state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] period_q;
    logic             oneshot_q;
    logic             tick_q;
    logic             done_q;

    logic [WIDTH-1:0] count_d;
    logic             expire;

    assign count_d = count_q + ONE;
    assign expire  = (count_q == (period_q - ONE));

    // stop beats start; a set from one-shot expiry beats a coincident clr_done
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            count_q   <= '0;
            period_q  <= '0;
            oneshot_q <= 1'b0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (clr_done_i) begin
                done_q <= 1'b0;
            end
            if (stop_i) begin
                state_q <= IDLE;
                count_q <= '0;
            end else if (start_i && (period_i != '0)) begin
                state_q   <= RUN;
                period_q  <= period_i;
                oneshot_q <= oneshot_i;
                count_q   <= '0;
                done_q    <= 1'b0;
            end else if ((state_q == RUN) && enable_i) begin
                if (expire) begin
                    tick_q  <= 1'b1;
                    count_q <= '0;
                    if (oneshot_q) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end else begin
                    count_q <= count_d;
                end
            end
        end
    end

    assign tick_o  = tick_q;
    assign busy_o  = (state_q == RUN);
    assign done_o  = done_q;
    assign count_o = count_q;

endmodule

// File: rtl/multi_tick_timer.sv
// Bank of NUM_CH independent tick timers; wiring only.
module multi_tick_timer
    import timer_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = TIMER_WIDTH_DEFAULT
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          enable_i,
    input  logic [NUM_CH-1:0]             start_i,
    input  logic [NUM_CH-1:0]             stop_i,
    input  logic [NUM_CH-1:0][WIDTH-1:0]  period_i,
    input  logic [NUM_CH-1:0]             oneshot_i,
    input  logic [NUM_CH-1:0]             clr_done_i,
    output logic [NUM_CH-1:0]             tick_o,
    output logic [NUM_CH-1:0]             busy_o,
    output logic [NUM_CH-1:0]             done_o,
    output logic [NUM_CH-1:0][WIDTH-1:0]  count_o
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        timer_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk_i      (clk_i),
            .reset_i    (reset_i),
            .enable_i   (enable_i),
            .start_i    (start_i[g]),
            .stop_i     (stop_i[g]),
            .period_i   (period_i[g]),
            .oneshot_i  (oneshot_i[g]),
            .clr_done_i (clr_done_i[g]),
            .tick_o     (tick_o[g]),
            .busy_o     (busy_o[g]),
            .done_o     (done_o[g]),
            .count_o    (count_o[g])
        );
    end

endmodule

// File: tb/tb_multi_tick_timer.sv
// Self-checking bench: directed table, corner-case sequences, randomized run vs reference model.
module tb_multi_tick_timer;

    localparam int NCH = 4;
    localparam int W   = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   en;
    logic [NCH-1:0]         st, sp, os, clr;
    logic [NCH-1:0][W-1:0]  per;
    logic [NCH-1:0]         tick, busy, done;
    logic [NCH-1:0][W-1:0]  cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model: remaining enabled cycles until the next tick
    int m_run[NCH], m_rem[NCH], m_p[NCH], m_os[NCH], m_done[NCH], m_tick[NCH];

    multi_tick_timer #(.NUM_CH(NCH), .WIDTH(W)) dut (
        .clk_i      (clk),
        .reset_i    (rst),
        .enable_i   (en),
        .start_i    (st),
        .stop_i     (sp),
        .period_i   (per),
        .oneshot_i  (os),
        .clr_done_i (clr),
        .tick_o     (tick),
        .busy_o     (busy),
        .done_o     (done),
        .count_o    (cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic           en;
        logic [3:0]     st, sp, os, clr;
        logic [7:0]     p0, p1;
        logic [3:0]     x_tick, x_busy, x_done;
        logic [7:0]     x_c0, x_c1;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_run[c] = 0; m_rem[c] = 0; m_p[c] = 0;
            m_os[c] = 0; m_done[c] = 0; m_tick[c] = 0;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < NCH; c++) begin
            m_tick[c] = 0;
            if (clr[c]) m_done[c] = 0;
            if (sp[c]) begin
                m_run[c] = 0;
            end else if (st[c] && per[c] != 0) begin
                m_run[c] = 1; m_p[c] = int'(per[c]); m_os[c] = int'(os[c]);
                m_rem[c] = m_p[c]; m_done[c] = 0;
            end else if (m_run[c] == 1 && en) begin
                m_rem[c]--;
                if (m_rem[c] == 0) begin
                    m_tick[c] = 1;
                    if (m_os[c] == 1) begin
                        m_run[c] = 0; m_done[c] = 1;
                    end else begin
                        m_rem[c] = m_p[c];
                    end
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [NCH-1:0] xt, xb, xd;
        for (int c = 0; c < NCH; c++) begin
            xt[c] = (m_tick[c] == 1);
            xb[c] = (m_run[c] == 1);
            xd[c] = (m_done[c] == 1);
            chk({tag, "_count"}, int'(cnt[c]), (m_run[c] == 1) ? m_p[c] - m_rem[c] : 0);
        end
        chk({tag, "_tick"}, int'(tick), int'(xt));
        chk({tag, "_busy"}, int'(busy), int'(xb));
        chk({tag, "_done"}, int'(done), int'(xd));
    endtask

    task automatic edge_(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    task automatic idle_inputs();
        st = '0; sp = '0; clr = '0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 4'b0011, 4'b0000, 4'b0010, 4'b0000, 8'd5, 8'd3, 4'b0000, 4'b0011, 4'b0000, 8'd0, 8'd0};
        tbl[1]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd5, 8'd3, 4'b0000, 4'b0011, 4'b0000, 8'd1, 8'd1};
        tbl[2]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd5, 8'd3, 4'b0000, 4'b0011, 4'b0000, 8'd2, 8'd2};
        tbl[3]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd5, 8'd3, 4'b0010, 4'b0001, 4'b0010, 8'd3, 8'd0};
        tbl[4]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 8'd5, 8'd3, 4'b0000, 4'b0001, 4'b0000, 8'd4, 8'd0};
        tbl[5]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd5, 8'd3, 4'b0001, 4'b0001, 4'b0000, 8'd0, 8'd0};
        tbl[6]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd9, 8'd3, 4'b0000, 4'b0001, 4'b0000, 8'd1, 8'd0};
        tbl[7]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd9, 8'd3, 4'b0000, 4'b0001, 4'b0000, 8'd2, 8'd0};
        tbl[8]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd9, 8'd3, 4'b0000, 4'b0001, 4'b0000, 8'd3, 8'd0};
        tbl[9]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd9, 8'd3, 4'b0000, 4'b0001, 4'b0000, 8'd4, 8'd0};
        tbl[10] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd9, 8'd3, 4'b0001, 4'b0001, 4'b0000, 8'd0, 8'd0};
        tbl[11] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd9, 8'd3, 4'b0000, 4'b0001, 4'b0000, 8'd0, 8'd0};
        tbl[12] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd9, 8'd3, 4'b0000, 4'b0001, 4'b0000, 8'd1, 8'd0};
        tbl[13] = '{1'b1, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 8'd9, 8'd3, 4'b0000, 4'b0000, 4'b0000, 8'd0, 8'd0};

        rst = 1'b1; en = 1'b1; idle_inputs(); os = '0; per = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        rst = 1'b0;

        // directed table: ch0 periodic P=5, ch1 one-shot P=3, clr_done, pause, stop
        for (int i = 0; i < 14; i++) begin
            en = tbl[i].en; st = tbl[i].st; sp = tbl[i].sp; os = tbl[i].os; clr = tbl[i].clr;
            per[0] = tbl[i].p0; per[1] = tbl[i].p1;
            edge_("tbl");
            chk($sformatf("tbl%0d_tick", i), int'(tick), int'(tbl[i].x_tick));
            chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].x_busy));
            chk($sformatf("tbl%0d_done", i), int'(done), int'(tbl[i].x_done));
            chk($sformatf("tbl%0d_c0", i), int'(cnt[0]), int'(tbl[i].x_c0));
            chk($sformatf("tbl%0d_c1", i), int'(cnt[1]), int'(tbl[i].x_c1));
        end
        idle_inputs(); os = '0; en = 1'b1;

        // pause: P=4 with two disabled cycles -> first tick six edges after start
        per[0] = 8'd4; st = 4'b0001;
        edge_("pause"); idle_inputs();
        edge_("pause"); edge_("pause");
        en = 1'b0;
        edge_("pause"); chk("pause_hold_a", int'(cnt[0]), 2);
        edge_("pause"); chk("pause_hold_b", int'(cnt[0]), 2);
        chk("pause_no_tick", int'(tick[0]), 0);
        en = 1'b1;
        edge_("pause"); chk("pause_pre_tick", int'(tick[0]), 0);
        edge_("pause"); chk("pause_tick_e6", int'(tick[0]), 1);
        sp = 4'b0001; edge_("pause"); idle_inputs();

        // restart at count 3 suppresses the due tick; start+stop together keeps ch3 idle
        per[2] = 8'd4; st = 4'b0100;
        edge_("rst2"); idle_inputs();
        repeat (3) edge_("rst2");
        chk("restart_cnt3", int'(cnt[2]), 3);
        per[3] = 8'd6; st = 4'b1100; sp = 4'b1000;
        edge_("rst2");
        chk("restart_no_tick", int'(tick[2]), 0);
        chk("restart_cnt0", int'(cnt[2]), 0);
        chk("start_stop_idle", int'(busy[3]), 0);
        idle_inputs();
        repeat (3) begin
            edge_("rst2");
            chk("restart_early", int'(tick[2]), 0);
        end
        edge_("rst2"); chk("restart_tick4", int'(tick[2]), 1);
        sp = 4'b0100; edge_("rst2"); idle_inputs();

        // zero period ignored; clr_done coinciding with one-shot expiry leaves done set
        per[1] = 8'd0; st = 4'b0010;
        edge_("p0"); idle_inputs();
        chk("period0_idle", int'(busy[1]), 0);
        per[1] = 8'd2; os = 4'b0010; st = 4'b0010;
        edge_("clrx"); idle_inputs(); os = '0;
        edge_("clrx");
        clr = 4'b0010;
        edge_("clrx");
        chk("clr_vs_set_tick", int'(tick[1]), 1);
        chk("clr_vs_set_done", int'(done[1]), 1);
        idle_inputs();

        // asynchronous reset with all channels running
        per[0] = 8'd3; per[1] = 8'd5; per[2] = 8'd7; per[3] = 8'd9; st = 4'b1111;
        edge_("arst"); idle_inputs();
        repeat (2) edge_("arst");
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_model("arst_now");
        chk("arst_busy", int'(busy), 0);
        edge_("arst_hold");
        #2;
        rst = 1'b0;
        repeat (10) edge_("arst_after");
        chk("arst_no_tick", int'(tick), 0);

        // randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 7) != 0);
            for (int c = 0; c < NCH; c++) begin
                st[c]  = ($urandom_range(0, 11) == 0);
                sp[c]  = ($urandom_range(0, 29) == 0);
                clr[c] = ($urandom_range(0, 9) == 0);
                os[c]  = $urandom_range(0, 1);
                per[c] = 8'($urandom_range(0, 9));
            end
            edge_("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
